// File: rtl/pdp11_pkg.sv
// Shared PDP-11 definitions: bus-unit state encoding, byte-lane codes, trap vectors.
// Pure declarations, no logic; imported by the bus unit and the control unit.
// Lane helper keeps the byte/word lane decode in one place.
package pdp11_pkg;

  typedef enum logic [1:0] {
    BU_IDLE = 2'd0,
    BU_BUS  = 2'd1,
    BU_DONE = 2'd2,
    BU_ERR  = 2'd3
  } bu_state_t;

  localparam logic [1:0] LANE_LO   = 2'b01;
  localparam logic [1:0] LANE_HI   = 2'b10;
  localparam logic [1:0] LANE_WORD = 2'b11;

  // Vector the control unit jumps through when the bus unit reports err.
  localparam logic [15:0] TRAP_BUSERR = 16'o4;

  // Byte-lane enables for an access: word uses both lanes, byte picks by addr[0].
  function automatic logic [1:0] lane_sel(input logic bytew, input logic a0);
    if (!bytew) return LANE_WORD;
    return a0 ? LANE_HI : LANE_LO;
  endfunction

endpackage

// File: rtl/bus_unit.sv
// Memory bus adapter: datapath word/byte request -> wait-stated external bus cycle.
// Latency: ack 2 cycles after req with a zero-wait slave; odd-address err 1 cycle after req.
// Backpressure: slave stalls via bus_rdy (bounded by TIMEOUT); req only sampled in IDLE, never queued.
module bus_unit
  import pdp11_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic          bytew,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata,
  output logic          ack,
  output logic          err,
  output logic          err_odd,
  output logic [AW-1:0] bus_addr,
  output logic [15:0]   bus_wdata,
  output logic [1:0]    bus_lane,
  output logic          bus_rd,
  output logic          bus_wr,
  input  logic [15:0]   bus_rdata,
  input  logic          bus_rdy
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  bu_state_t     state, state_nxt;
  logic [CW-1:0] cnt;
  logic          cap_we, cap_bytew, cap_hi;
  logic [AW-1:0] cap_addr;
  logic [15:0]   cap_wdata;
  logic [1:0]    cap_lane;

  logic req_odd, req_start, bus_done, bus_tmo;

  // Word access to an odd address is rejected before any bus cycle starts.
  assign req_odd   = (state == BU_IDLE) && req && !bytew && addr[0];
  assign req_start = (state == BU_IDLE) && req && !(!bytew && addr[0]);
  // Ready wins over timeout when both land in the same cycle.
  assign bus_done  = (state == BU_BUS) && bus_rdy;
  assign bus_tmo   = (state == BU_BUS) && !bus_rdy && (cnt == CNT_LAST);

  // State register; reset drops the strobes immediately since they decode from state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BU_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      BU_IDLE: begin
        if (req_odd)        state_nxt = BU_ERR;
        else if (req_start) state_nxt = BU_BUS;
      end
      BU_BUS: begin
        if (bus_done)     state_nxt = BU_DONE;
        else if (bus_tmo) state_nxt = BU_ERR;
      end
      BU_DONE: state_nxt = BU_IDLE;
      BU_ERR:  state_nxt = BU_IDLE;
      default: state_nxt = BU_IDLE;
    endcase
  end

  // Wait counter: runs only while the bus cycle is active, cleared otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (state == BU_BUS)  cnt <= cnt + CW'(1);
    else                       cnt <= '0;
  end

  // Capture the request so bus outputs stay stable through the whole bus cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_we    <= 1'b0;
      cap_bytew <= 1'b0;
      cap_hi    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_lane  <= '0;
    end else if (req_start) begin
      cap_we    <= we;
      cap_bytew <= bytew;
      cap_hi    <= addr[0];
      cap_addr  <= {addr[AW-1:1], 1'b0};
      cap_wdata <= bytew ? {wdata[7:0], wdata[7:0]} : wdata;
      cap_lane  <= lane_sel(bytew, addr[0]);
    end
  end

  // Read data latches on read completion only; byte reads are zero-extended.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (bus_done && !cap_we) begin
      if (cap_bytew) rdata <= {8'h00, (cap_hi ? bus_rdata[15:8] : bus_rdata[7:0])};
      else           rdata <= bus_rdata;
    end
  end

  // Error qualifier, updated only when a new error is raised.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err_odd <= 1'b0;
    else if (req_odd) err_odd <= 1'b1;
    else if (bus_tmo) err_odd <= 1'b0;
  end

  assign ack       = (state == BU_DONE);
  assign err       = (state == BU_ERR);
  assign bus_addr  = cap_addr;
  assign bus_wdata = cap_wdata;
  assign bus_lane  = cap_lane;
  assign bus_rd    = (state == BU_BUS) && !cap_we;
  assign bus_wr    = (state == BU_BUS) && cap_we;

endmodule

// File: tb/tb_bus_unit.sv
// Directed bench for bus_unit: table of accesses against a wait-programmable slave,
// plus hand sequences for back-to-back requests and reset during a bus cycle.
module tb_bus_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, bytew;
  logic [15:0] addr, wdata;
  logic [15:0] rdata;
  logic        ack, err, err_odd;
  logic [15:0] bus_addr, bus_wdata;
  logic [1:0]  bus_lane;
  logic        bus_rd, bus_wr;
  logic [15:0] bus_rdata;
  logic        bus_rdy;

  int checks = 0;
  int errors = 0;

  bus_unit #(.TIMEOUT(16), .AW(16)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .bytew(bytew), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .err_odd(err_odd),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_lane(bus_lane),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_rdata(bus_rdata), .bus_rdy(bus_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        bytew;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          waits;       // BUS cycles before rdy; 255 = slave never answers
    logic [15:0] brdata;
    logic        exp_err;
    logic        exp_odd;
    logic [15:0] exp_baddr;
    logic [1:0]  exp_lane;
    logic [15:0] exp_bwdata;
    logic [15:0] exp_rdata;
    int          exp_strobes;
    int          exp_lat;     // cycles from req cycle to ack/err
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   strobes = 0;
    int   lat = 0;
    logic got_ack = 1'b0, got_err = 1'b0;
    logic bad_bus = 1'b0;
    string tag;
    tag = $sformatf("v%0d", idx);
    req = 1'b1; we = v.we; bytew = v.bytew; addr = v.addr; wdata = v.wdata;
    bus_rdata = v.brdata; bus_rdy = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req = 1'b0;
      bus_rdy = 1'b0;
      if (bus_rd || bus_wr) begin
        strobes++;
        if (bus_rd === v.we || bus_wr !== v.we) bad_bus = 1'b1;
        if (bus_addr !== v.exp_baddr || bus_lane !== v.exp_lane || bus_wdata !== v.exp_bwdata)
          bad_bus = 1'b1;
        if (v.waits != 255 && strobes == v.waits + 1) bus_rdy = 1'b1;
      end
      if (ack || err) begin
        got_ack = ack; got_err = err; lat = k;
        break;
      end
    end
    check({tag, "_kind"}, {30'd0, got_ack, got_err}, {30'd0, !v.exp_err, v.exp_err});
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_strobes"}, strobes, v.exp_strobes);
    if (v.exp_strobes > 0) check({tag, "_bus_fields"}, {31'd0, bad_bus}, 32'd0);
    check({tag, "_rdata"}, {16'd0, rdata}, {16'd0, v.exp_rdata});
    if (v.exp_err) check({tag, "_err_odd"}, {31'd0, err_odd}, {31'd0, v.exp_odd});
    @(negedge clk);
    check({tag, "_pulse_end"}, {28'd0, ack, err, bus_rd, bus_wr}, 32'd0);
  endtask

  initial begin
    logic [5:0] ack_pat, rd_pat;
    logic       seen;

    //           we    bytew addr      wdata     waits brdata     err   odd   baddr     lane   bwdata    rdata     strb lat
    vecs[0] = '{1'b0, 1'b0, 16'o1000, 16'h1234, 3,   16'o123456, 1'b0, 1'b0, 16'o1000, 2'b11, 16'h1234, 16'o123456, 4, 5};
    vecs[1] = '{1'b1, 1'b1, 16'o1001, 16'o377,  0,   16'h0000,   1'b0, 1'b0, 16'o1000, 2'b10, 16'hFFFF, 16'o123456, 1, 2};
    vecs[2] = '{1'b0, 1'b1, 16'o1001, 16'h0000, 1,   16'hA55A,   1'b0, 1'b0, 16'o1000, 2'b10, 16'h0000, 16'h00A5,   2, 3};
    vecs[3] = '{1'b0, 1'b0, 16'o1003, 16'h0000, 0,   16'h0000,   1'b1, 1'b1, 16'o1002, 2'b11, 16'h0000, 16'h00A5,   0, 1};
    vecs[4] = '{1'b0, 1'b0, 16'o2000, 16'h7777, 255, 16'h0000,   1'b1, 1'b0, 16'o2000, 2'b11, 16'h7777, 16'h00A5,  16, 17};
    vecs[5] = '{1'b0, 1'b1, 16'o2000, 16'h12C3, 0,   16'hA55A,   1'b0, 1'b0, 16'o2000, 2'b01, 16'hC3C3, 16'h005A,   1, 2};
    vecs[6] = '{1'b1, 1'b0, 16'o177776, 16'hBEEF, 2, 16'h0000,   1'b0, 1'b0, 16'o177776, 2'b11, 16'hBEEF, 16'h005A, 3, 4};
    vecs[7] = '{1'b0, 1'b0, 16'o177776, 16'h0000, 0, 16'h8001,   1'b0, 1'b0, 16'o177776, 2'b11, 16'h0000, 16'h8001, 1, 2};
    vecs[8] = '{1'b1, 1'b1, 16'o3000, 16'hAB12, 0,   16'h0000,   1'b0, 1'b0, 16'o3000, 2'b01, 16'h1212, 16'h8001,   1, 2};
    vecs[9] = '{1'b0, 1'b0, 16'o6000, 16'h0000, 0,   16'h2222,   1'b0, 1'b0, 16'o6000, 2'b11, 16'h0000, 16'h2222,   1, 2};

    reset = 1'b0; req = 1'b0; we = 1'b0; bytew = 1'b0; addr = '0; wdata = '0;
    bus_rdata = '0; bus_rdy = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {rdata, 8'd0, ack, err, err_odd, bus_rd, bus_wr, bus_lane, 1'b0},
          32'd0);
    check("reset_bus_addr_wdata", {bus_addr, bus_wdata}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // req held high with a zero-wait slave: ack every third cycle.
    req = 1'b1; we = 1'b0; bytew = 1'b0; addr = 16'o4000; wdata = '0;
    bus_rdata = 16'h1111; bus_rdy = 1'b1;
    ack_pat = '0; rd_pat = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ack_pat[k] = ack;
      rd_pat[k]  = bus_rd;
    end
    req = 1'b0; bus_rdy = 1'b0;
    check("b2b_ack_pattern", {26'd0, ack_pat}, {26'd0, 6'b010010});
    check("b2b_rd_pattern", {26'd0, rd_pat}, {26'd0, 6'b001001});
    check("b2b_rdata", {16'd0, rdata}, {16'd0, 16'h1111});
    @(negedge clk);

    // Reset asserted between edges in the middle of a stalled write.
    req = 1'b1; we = 1'b1; bytew = 1'b0; addr = 16'o5000; wdata = 16'h5555; bus_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req = 1'b0;
    end
    check("pre_reset_bus_wr", {31'd0, bus_wr}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_strobes", {28'd0, bus_rd, bus_wr, ack, err}, 32'd0);
    check("async_reset_rdata", {16'd0, rdata}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | ack | err | bus_rd | bus_wr;
    end
    check("post_reset_quiet", {31'd0, seen}, 32'd0);
    run_vec(9, vecs[9]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
